// File: rtl/sram_to_stream_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_to_stream_drain
//
// Purpose:
//   Reads a programmable number of UNIT_LEN-element words from a result SRAM,
//   starting at address 0. The SRAM has a fixed read latency. Each word is
//   serialised into OUT_LANES-element beats on a valid/ready stream. Reads are
//   only issued while the FIFO can absorb them: buffered words plus reads
//   still in flight must stay below FIFO_DEPTH. Stream backpressure can
//   therefore never drop SRAM read data.
//
// Ports:
//   clk        single clock
//   reset      asynchronous, active-high reset
//   cke        clock enable; every register holds its value while low
//   start      one-cycle request to begin a drain (ignored while busy)
//   size       number of words to drain minus 1, sampled on accepted start
//   busy       high from accepted start until done
//   done       one-cycle pulse after the final beat has been accepted
//   mem_ren    SRAM read enable
//   mem_raddr  SRAM read address
//   mem_rdata  SRAM read data, element i at [i*DATA_BITS +: DATA_BITS]
//   m_data     beat data, same element packing
//   m_last     end-of-drain marker (or end-of-word, see below)
//   m_valid    beat valid
//   m_ready    downstream accept
//
// Build option:
//   SRAM_TO_STREAM_DRAIN_LAST_PER_UNIT_EN
//     defined   : m_last marks the last beat of every SRAM word.
//     undefined : m_last marks only the final beat of the whole drain.
//   The timing of done is the same in both builds.
//
// Parameter constraints:
//   UNIT_LEN must be a multiple of OUT_LANES.
//   FIFO_DEPTH must be a power of 2 and >= READ_LATENCY+1.
// -----------------------------------------------------------------------------
module sram_to_stream_drain #(
  parameter int ADDR_BITS    = 10,
  parameter int DATA_BITS    = 8,
  parameter int UNIT_LEN     = 64,
  parameter int OUT_LANES    = 8,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cke,
  input  logic                          start,
  input  logic [ADDR_BITS-1:0]          size,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_ren,
  output logic [ADDR_BITS-1:0]          mem_raddr,
  input  logic [UNIT_LEN*DATA_BITS-1:0] mem_rdata,
  output logic [OUT_LANES*DATA_BITS-1:0] m_data,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready
);

  localparam int WORD_W = UNIT_LEN * DATA_BITS;
  localparam int BEAT_W = OUT_LANES * DATA_BITS;
  localparam int BEATS  = UNIT_LEN / OUT_LANES;
  localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;   // holds 0..FIFO_DEPTH
  localparam int OCC_W  = CNT_W + 1;                // buffered + in flight

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]              state_reg;
  logic [ADDR_BITS-1:0]    size_reg;
  logic [ADDR_BITS-1:0]    raddr_reg;
  logic                    done_reg;

  // Read-latency tracking. Bit gi is set gi+1 cke cycles after an issue.
  // last_sr_reg marks the read of address size_reg.
  logic [READ_LATENCY-1:0] valid_sr_reg;
  logic [READ_LATENCY-1:0] last_sr_reg;
  logic [READ_LATENCY-1:0] valid_sr_next;
  logic [READ_LATENCY-1:0] last_sr_next;

  // Word FIFO. The data array has no reset; validity is tracked by the
  // pointers and the count.
  logic [WORD_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last_reg;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [LANE_W-1:0]       lane_reg;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        inflight;
  logic [OCC_W-1:0]        occupancy;
  logic                    credit_ok;
  logic                    issue;
  logic                    issue_last;
  logic                    push;
  logic                    xfer;
  logic                    beat_end;
  logic                    pop;
  logic                    final_beat;
  logic [WORD_W-1:0]       head_word;
  logic [BEAT_W-1:0]       head_beats [BEATS];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(valid_sr_reg[i]);
    end
  end

  // Count reads in flight, not only buffered words. An issue is therefore
  // always backed by a FIFO slot, however long the stream stalls.
  assign occupancy  = OCC_W'(count_reg) + OCC_W'(inflight);
  assign credit_ok  = occupancy < OCC_W'(FIFO_DEPTH);

  assign mem_ren    = (state_reg == S_READ) && credit_ok;
  assign mem_raddr  = raddr_reg;
  assign issue      = mem_ren && cke;
  assign issue_last = (raddr_reg == size_reg);

  // The oldest shift-register stage lines up with mem_rdata being valid.
  assign push       = cke && valid_sr_reg[READ_LATENCY-1];

  assign m_valid    = (count_reg != '0);
  assign xfer       = m_valid && m_ready && cke;
  assign beat_end   = (lane_reg == LAST_LANE);
  assign pop        = xfer && beat_end;
  assign final_beat = m_valid && beat_end && fifo_last_reg[rd_ptr_reg];

  assign head_word  = fifo_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign head_beats[gi] = head_word[gi*BEAT_W +: BEAT_W];
    end

    for (gi = 0; gi < READ_LATENCY; gi++) begin : g_lat
      if (gi == 0) begin : g_first
        assign valid_sr_next[gi] = issue;
        assign last_sr_next[gi]  = issue && issue_last;
      end else begin : g_shift
        assign valid_sr_next[gi] = valid_sr_reg[gi-1];
        assign last_sr_next[gi]  = last_sr_reg[gi-1];
      end
    end
  endgenerate

  // The head word and lane change only on an accepted beat. Holding m_ready
  // low therefore keeps m_data and m_last stable. Pushes go to a different slot.
  assign m_data = m_valid ? head_beats[lane_reg] : '0;

`ifdef SRAM_TO_STREAM_DRAIN_LAST_PER_UNIT_EN
  assign m_last = m_valid && beat_end;
`else
  assign m_last = final_beat;
`endif

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      size_reg      <= '0;
      raddr_reg     <= '0;
      done_reg      <= 1'b0;
      valid_sr_reg  <= '0;
      last_sr_reg   <= '0;
      fifo_last_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      lane_reg      <= '0;
    end else if (cke) begin
      done_reg     <= 1'b0;
      valid_sr_reg <= valid_sr_next;
      last_sr_reg  <= last_sr_next;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            size_reg  <= size;
            raddr_reg <= '0;
            state_reg <= S_READ;
          end
        end
        S_READ: begin
          if (mem_ren) begin
            // On the final issue the address may wrap (size = all ones).
            // The FSM has already left READ by then.
            raddr_reg <= raddr_reg + 1'b1;
            if (issue_last) begin
              state_reg <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // The final word is the last one pushed. When its last beat is
          // accepted the FIFO is empty and nothing is in flight.
          if (xfer && final_beat) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      if (push) begin
        fifo_last_reg[wr_ptr_reg] <= last_sr_reg[READ_LATENCY-1];
        wr_ptr_reg                <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (xfer) begin
        lane_reg <= beat_end ? '0 : lane_reg + 1'b1;
      end
    end
  end

  // Word storage. Written only when a read's data arrives.
  always_ff @(posedge clk) begin
    if (cke && push) begin
      fifo_mem[wr_ptr_reg] <= mem_rdata;
    end
  end

endmodule
